serializador_vetor: RTL and testbench

Streams a sorted vector out one element per transfer over a valid/ready handshake. It sits at the output end of the sorting stage: it snapshots the sorter's parallel vector and length on a load pulse, then emits the elements in index order. While streaming, it checks that the sequence is non-decreasing and flags any violation.

---
 rtl/serializador_vetor.sv | 160 ++++++++++++++++
 tb/tb_serializador_vetor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serializador_vetor.sv
// Snapshots a parallel vector on a load pulse and streams its elements in index
// order over valid/ready, flagging any decrease between consecutive transfers.
module serializador_vetor #(
  parameter int unsigned N_ELEM = 6,
  parameter int unsigned LARG   = 4,
  parameter int unsigned TAM_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_ELEM*LARG-1:0]   vet_in,
  input  logic [TAM_W-1:0]         tam,
  input  logic                     carregar,
  input  logic                     abortar,
  output logic [LARG-1:0]          dado_out,
  output logic                     valido,
  input  logic                     pronto,
  output logic                     ultimo,
  output logic                     ocupado,
  output logic                     concluido,
  output logic                     erro_ordem
);

  localparam int unsigned IW = $clog2(N_ELEM + 1);

  typedef enum logic [1:0] {
    OCIOSO,
    ENVIANDO,
    FIM
  } estado_t;

  estado_t         estado_q, estado_d;
  logic [LARG-1:0] mem_q [N_ELEM];
  logic [LARG-1:0] mem_d [N_ELEM];
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   tam_ef_q, tam_ef_d;
  logic [LARG-1:0] prev_q, prev_d;

  logic [LARG-1:0] dado_d;
  logic            valido_d;
  logic            ultimo_d;
  logic            ocupado_d;
  logic            concluido_d;
  logic            erro_d;

  logic [IW-1:0]   idx_inc;
  logic [IW-1:0]   tam_sat;

  always_comb begin
    if (32'(tam) > N_ELEM) tam_sat = IW'(N_ELEM);
    else                   tam_sat = IW'(tam);
  end

  // Outputs are computed one cycle ahead and registered, so pronto only
  // reaches the outputs through flops.
  always_comb begin
    estado_d    = estado_q;
    mem_d       = mem_q;
    idx_d       = idx_q;
    tam_ef_d    = tam_ef_q;
    prev_d      = prev_q;
    dado_d      = dado_out;
    valido_d    = valido;
    ultimo_d    = ultimo;
    ocupado_d   = ocupado;
    concluido_d = 1'b0;
    erro_d      = erro_ordem;
    idx_inc     = idx_q + 1'b1;

    case (estado_q)
      OCIOSO: begin
        if (carregar) begin
          for (int unsigned i = 0; i < N_ELEM; i++)
            mem_d[i] = vet_in[i*LARG +: LARG];
          tam_ef_d  = tam_sat;
          idx_d     = '0;
          erro_d    = 1'b0;
          ocupado_d = 1'b1;
          if (tam_sat == '0) begin
            estado_d    = FIM;
            valido_d    = 1'b0;
            ultimo_d    = 1'b0;
            concluido_d = 1'b1;
          end else begin
            estado_d = ENVIANDO;
            valido_d = 1'b1;
            dado_d   = vet_in[LARG-1:0];
            ultimo_d = (tam_sat == IW'(1));
          end
        end
      end

      ENVIANDO: begin
        if (abortar) begin
          estado_d  = OCIOSO;
          valido_d  = 1'b0;
          ultimo_d  = 1'b0;
          ocupado_d = 1'b0;
        end else if (pronto) begin
          if (idx_q != '0 && dado_out < prev_q)
            erro_d = 1'b1;
          prev_d = dado_out;
          if (ultimo) begin
            estado_d    = FIM;
            valido_d    = 1'b0;
            ultimo_d    = 1'b0;
            concluido_d = 1'b1;
          end else begin
            idx_d    = idx_inc;
            dado_d   = mem_q[idx_inc];
            ultimo_d = (idx_inc == tam_ef_q - IW'(1));
          end
        end
      end

      FIM: begin
        estado_d  = OCIOSO;
        valido_d  = 1'b0;
        ultimo_d  = 1'b0;
        ocupado_d = 1'b0;
      end

      default: begin
        estado_d  = OCIOSO;
        valido_d  = 1'b0;
        ultimo_d  = 1'b0;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      for (int unsigned i = 0; i < N_ELEM; i++)
        mem_q[i] <= '0;
      idx_q      <= '0;
      tam_ef_q   <= '0;
      prev_q     <= '0;
      dado_out   <= '0;
      valido     <= 1'b0;
      ultimo     <= 1'b0;
      ocupado    <= 1'b0;
      concluido  <= 1'b0;
      erro_ordem <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      mem_q      <= mem_d;
      idx_q      <= idx_d;
      tam_ef_q   <= tam_ef_d;
      prev_q     <= prev_d;
      dado_out   <= dado_d;
      valido     <= valido_d;
      ultimo     <= ultimo_d;
      ocupado    <= ocupado_d;
      concluido  <= concluido_d;
      erro_ordem <= erro_d;
    end
  end

endmodule

// File: tb/tb_serializador_vetor.sv
// Directed bench for serializador_vetor: sorted streams, stalls, order errors,
// length saturation, abort, ignored loads and asynchronous reset.
module tb_serializador_vetor;

  logic        clk;
  logic        rst_n;
  logic [23:0] vet_in;
  logic [2:0]  tam;
  logic        carregar;
  logic        abortar;
  logic [3:0]  dado_out;
  logic        valido;
  logic        pronto;
  logic        ultimo;
  logic        ocupado;
  logic        concluido;
  logic        erro_ordem;

  int checks = 0;
  int errors = 0;

  serializador_vetor #(.N_ELEM(6), .LARG(4), .TAM_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vet_in     (vet_in),
    .tam        (tam),
    .carregar   (carregar),
    .abortar    (abortar),
    .dado_out   (dado_out),
    .valido     (valido),
    .pronto     (pronto),
    .ultimo     (ultimo),
    .ocupado    (ocupado),
    .concluido  (concluido),
    .erro_ordem (erro_ordem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pack(input logic [3:0] e0, e1, e2, e3, e4, e5);
    return {e5, e4, e3, e2, e1, e0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [23:0] v, input logic [2:0] t);
    vet_in   = v;
    tam      = t;
    carregar = 1'b1;
    tick();
    carregar = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; carregar = 1'b0; abortar = 1'b0; pronto = 1'b0;
    vet_in = '0; tam = '0;
    tick(); tick();
    checks++; if ({dado_out, valido, ultimo, ocupado, concluido, erro_ordem} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0", {dado_out, valido, ultimo, ocupado, concluido, erro_ordem}); end
    rst_n = 1'b1;
    tick();
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_idle got %b exp 0", ocupado); end
  endtask

  task automatic test_sorted();
    logic [3:0] ex [6] = '{4'd1, 4'd3, 4'd3, 4'd7, 4'd9, 4'd12};
    pronto = 1'b1;
    load(pack(1, 3, 3, 7, 9, 12), 3'd6);
    for (int k = 0; k < 6; k++) begin
      checks++; if (valido !== 1'b1) begin errors++; $display("FAIL sorted_valido k=%0d got %b exp 1", k, valido); end
      checks++; if (dado_out !== ex[k]) begin errors++; $display("FAIL sorted_dado k=%0d got %0d exp %0d", k, dado_out, ex[k]); end
      checks++; if (ultimo !== (k == 5)) begin errors++; $display("FAIL sorted_ultimo k=%0d got %b exp %b", k, ultimo, k == 5); end
      checks++; if (concluido !== 1'b0) begin errors++; $display("FAIL sorted_early_concl k=%0d got %b exp 0", k, concluido); end
      tick();
    end
    checks++; if ({valido, concluido, ocupado, erro_ordem} !== 4'b0110) begin
      errors++; $display("FAIL sorted_fim got %b exp 0110", {valido, concluido, ocupado, erro_ordem}); end
    tick();
    checks++; if ({valido, concluido, ocupado, erro_ordem} !== 4'b0000) begin
      errors++; $display("FAIL sorted_idle got %b exp 0000", {valido, concluido, ocupado, erro_ordem}); end
  endtask

  task automatic test_stall();
    logic [3:0] ex [6] = '{4'd1, 4'd3, 4'd3, 4'd7, 4'd9, 4'd12};
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    int c = 0;
    pronto = 1'b0;
    load(pack(1, 3, 3, 7, 9, 12), 3'd6);
    vet_in = 24'hFFFFFF;
    tam    = 3'd2;
    while (k < 6 && c < 40) begin
      pronto = pat[c % 4];
      checks++; if (valido !== 1'b1) begin errors++; $display("FAIL stall_valido c=%0d got %b exp 1", c, valido); end
      checks++; if (dado_out !== ex[k]) begin errors++; $display("FAIL stall_dado c=%0d got %0d exp %0d", c, dado_out, ex[k]); end
      checks++; if (ultimo !== (k == 5)) begin errors++; $display("FAIL stall_ultimo c=%0d got %b exp %b", c, ultimo, k == 5); end
      tick();
      if (pronto) k++;
      c++;
    end
    pronto = 1'b1;
    checks++; if (k !== 6) begin errors++; $display("FAIL stall_timeout got %0d exp 6", k); end
    checks++; if ({valido, concluido} !== 2'b01) begin errors++; $display("FAIL stall_concl got %b exp 01", {valido, concluido}); end
    tick();
  endtask

  task automatic test_order();
    logic [3:0] ex [4] = '{4'd2, 4'd5, 4'd4, 4'd8};
    pronto = 1'b1;
    load(pack(2, 5, 4, 8, 1, 0), 3'd4);
    for (int k = 0; k < 4; k++) begin
      checks++; if (dado_out !== ex[k]) begin errors++; $display("FAIL order_dado k=%0d got %0d exp %0d", k, dado_out, ex[k]); end
      checks++; if (erro_ordem !== (k == 3)) begin errors++; $display("FAIL order_erro k=%0d got %b exp %b", k, erro_ordem, k == 3); end
      tick();
    end
    checks++; if ({concluido, erro_ordem} !== 2'b11) begin errors++; $display("FAIL order_concl got %b exp 11", {concluido, erro_ordem}); end
    tick();
    checks++; if (erro_ordem !== 1'b1) begin errors++; $display("FAIL order_sticky got %b exp 1", erro_ordem); end
    load(pack(0, 1, 2, 3, 4, 5), 3'd3);
    checks++; if (erro_ordem !== 1'b0) begin errors++; $display("FAIL order_clear got %b exp 0", erro_ordem); end
    tick(); tick(); tick();
    checks++; if ({concluido, erro_ordem} !== 2'b10) begin errors++; $display("FAIL order_clean_end got %b exp 10", {concluido, erro_ordem}); end
    tick();
  endtask

  task automatic test_tam_limits();
    int n = 0;
    int c = 0;
    pronto = 1'b1;
    load(pack(1, 2, 3, 4, 5, 6), 3'd0);
    checks++; if ({valido, concluido, ocupado} !== 3'b011) begin errors++; $display("FAIL tam0_fim got %b exp 011", {valido, concluido, ocupado}); end
    tick();
    checks++; if ({valido, concluido, ocupado} !== 3'b000) begin errors++; $display("FAIL tam0_idle got %b exp 000", {valido, concluido, ocupado}); end
    load(pack(1, 2, 3, 4, 5, 6), 3'd7);
    while (!concluido && c < 20) begin
      if (valido) begin
        n++;
        checks++; if (dado_out !== 4'(n)) begin errors++; $display("FAIL tam7_dado n=%0d got %0d exp %0d", n, dado_out, n); end
        checks++; if (ultimo !== (n == 6)) begin errors++; $display("FAIL tam7_ultimo n=%0d got %b exp %b", n, ultimo, n == 6); end
      end
      tick();
      c++;
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL tam7_count got %0d exp 6", n); end
    tick();
  endtask

  task automatic test_abort();
    pronto = 1'b1;
    load(pack(1, 3, 3, 7, 9, 12), 3'd6);
    tick(); tick();
    checks++; if (dado_out !== 4'd3) begin errors++; $display("FAIL abort_pre got %0d exp 3", dado_out); end
    abortar = 1'b1;
    tick();
    abortar = 1'b0;
    checks++; if ({valido, ocupado, concluido} !== 3'b000) begin errors++; $display("FAIL abort_drop got %b exp 000", {valido, ocupado, concluido}); end
    tick();
    checks++; if ({valido, concluido} !== 2'b00) begin errors++; $display("FAIL abort_no_concl got %b exp 00", {valido, concluido}); end
    abortar = 1'b1;
    load(pack(4, 6, 8, 10, 12, 14), 3'd6);
    abortar = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++; if ({valido, dado_out} !== {1'b1, 4'(4 + 2 * k)}) begin
        errors++; $display("FAIL abort_reload k=%0d got %0d exp %0d", k, dado_out, 4 + 2 * k); end
      tick();
    end
    checks++; if (concluido !== 1'b1) begin errors++; $display("FAIL abort_reload_concl got %b exp 1", concluido); end
    tick();
  endtask

  task automatic test_ignore_and_reset();
    pronto = 1'b1;
    load(pack(0, 1, 2, 3, 4, 5), 3'd6);
    tick(); tick();
    load(pack(9, 9, 9, 9, 9, 9), 3'd2);
    for (int k = 3; k < 6; k++) begin
      checks++; if ({valido, dado_out, ultimo} !== {1'b1, 4'(k), k == 5}) begin
        errors++; $display("FAIL ignore_load k=%0d got %0d exp %0d", k, dado_out, k); end
      tick();
    end
    checks++; if (concluido !== 1'b1) begin errors++; $display("FAIL ignore_concl got %b exp 1", concluido); end
    tick();
    load(pack(1, 2, 3, 4, 5, 6), 3'd6);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({dado_out, valido, ultimo, ocupado, concluido, erro_ordem} !== 9'd0) begin
      errors++; $display("FAIL async_reset got %b exp 0", {dado_out, valido, ultimo, ocupado, concluido, erro_ordem}); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({valido, ocupado} !== 2'b00) begin errors++; $display("FAIL reset_release got %b exp 00", {valido, ocupado}); end
  endtask

  initial begin
    test_reset();
    test_sorted();
    test_stall();
    test_order();
    test_tam_limits();
    test_abort();
    test_ignore_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
